// File: rtl/syllable_pkg.sv
// rtl/syllable_pkg.sv - shared types and tail-length table for the syllable sequencer
package syllable_pkg;

  localparam int SYL_W = 4;
  localparam int SYL_N = 16;

  typedef enum logic {
    IDLE,
    RUN
  } state_e;

  // Nibbles of immediate that follow each opcode; only 0xC..0xF carry a tail.
  localparam logic [3:0] TAIL_LEN [SYL_N] = '{
    4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0,
    4'd0, 4'd0, 4'd0, 4'd0, 4'd1, 4'd2, 4'd4, 4'd8
  };

  function automatic logic [3:0] tail_len(input logic [3:0] opc);
    return TAIL_LEN[opc];
  endfunction

endpackage

// File: rtl/syllable_sequencer_tail_gather.sv
// rtl/syllable_sequencer_tail_gather.sv - assembles the tail nibbles after pc into a right-aligned immediate
module tail_gather
  import syllable_pkg::*;
#(
  parameter int IMM_W    = 32,
  parameter int MAX_TAIL = 8
) (
  input  logic [63:0]      bun_i,
  input  logic [3:0]       pc_i,
  input  logic [3:0]       len_i,
  output logic [IMM_W-1:0] imm_o,
  output logic             trunc_o
);

  localparam int WIN_W = SYL_W * MAX_TAIL;

  logic [127:0]       ext;
  logic [6:0]         sh;
  logic [WIN_W-1:0]   win;
  logic [IMM_W-1:0]   acc;

  // Zero padding above the bundle makes nibbles past syllable 15 read as 0.
  assign ext = {64'd0, bun_i};
  assign sh  = {1'b0, pc_i, 2'b00} + 7'd4;
  assign win = WIN_W'(ext >> sh);

  always_comb begin
    acc = '0;
    for (int j = 0; j < MAX_TAIL; j++) begin
      if (j < int'(len_i)) begin
        acc = {acc[IMM_W-SYL_W-1:0], win[SYL_W*j +: SYL_W]};
      end
    end
  end

  assign imm_o   = acc;
  assign trunc_o = ({1'b0, pc_i} + {1'b0, len_i}) > 5'd15;

endmodule

// File: rtl/syllable_sequencer.sv
// rtl/syllable_sequencer.sv - walks a 64-bit bundle emitting (opcode, immediate) pairs
// Optional one-bundle prefetch buffer enabled by SYLLABLE_SEQ_PREFETCH_EN.
module syllable_sequencer
  import syllable_pkg::*;
#(
  parameter int IMM_W    = 32,
  parameter int MAX_TAIL = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [63:0]      ir,
  input  logic             ir_valid,
  output logic             ir_ready,
  input  logic             flush,
  output logic             op_valid,
  input  logic             op_ready,
  output logic [3:0]       op,
  output logic [IMM_W-1:0] imm,
  output logic [3:0]       op_pc,
  output logic             op_trunc,
  output logic             op_last
);

  state_e      state_q;
  logic [3:0]  pc_q;
  logic [63:0] bun_q;

  logic             run;
  logic [3:0]       cur_op;
  logic [3:0]       len;
  logic [4:0]       nxt;
  logic [IMM_W-1:0] imm_raw;
  logic             trunc_raw;
  logic             op_acc;
  logic             ir_acc;

  assign run    = (state_q == RUN);
  assign cur_op = bun_q[{pc_q, 2'b00} +: 4];
  assign len    = tail_len(cur_op);
  // Five bits so that running past syllable 15 ends the bundle instead of wrapping.
  assign nxt    = {1'b0, pc_q} + 5'd1 + {1'b0, len};

  tail_gather #(
    .IMM_W    (IMM_W),
    .MAX_TAIL (MAX_TAIL)
  ) u_tail_gather (
    .bun_i   (bun_q),
    .pc_i    (pc_q),
    .len_i   (len),
    .imm_o   (imm_raw),
    .trunc_o (trunc_raw)
  );

  assign op_valid = run;
  assign op       = run ? cur_op : 4'd0;
  assign imm      = run ? imm_raw : '0;
  assign op_pc    = run ? pc_q : 4'd0;
  assign op_trunc = run & trunc_raw;
  assign op_last  = run & nxt[4];

  assign op_acc = run & op_ready;
  assign ir_acc = ir_valid & ir_ready;

`ifdef SYLLABLE_SEQ_PREFETCH_EN
  logic [63:0] nbun_q;
  logic        nv_q;

  assign ir_ready = !nv_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= 4'd0;
      bun_q   <= 64'd0;
      nbun_q  <= 64'd0;
      nv_q    <= 1'b0;
    end else if (flush) begin
      state_q <= IDLE;
      pc_q    <= 4'd0;
      nv_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ir_acc) begin
            bun_q   <= ir;
            pc_q    <= 4'd0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (op_acc && op_last) begin
            if (nv_q) begin
              bun_q <= nbun_q;
              pc_q  <= 4'd0;
              nv_q  <= 1'b0;
            end else if (ir_acc) begin
              bun_q <= ir;
              pc_q  <= 4'd0;
            end else begin
              state_q <= IDLE;
              pc_q    <= 4'd0;
            end
          end else begin
            if (op_acc) pc_q <= nxt[3:0];
            if (ir_acc) begin
              nbun_q <= ir;
              nv_q   <= 1'b1;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`else
  assign ir_ready = !run;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= 4'd0;
      bun_q   <= 64'd0;
    end else if (flush) begin
      state_q <= IDLE;
      pc_q    <= 4'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (ir_acc) begin
            bun_q   <= ir;
            pc_q    <= 4'd0;
            state_q <= RUN;
          end
        end
        RUN: begin
          if (op_acc) begin
            if (op_last) begin
              state_q <= IDLE;
              pc_q    <= 4'd0;
            end else begin
              pc_q <= nxt[3:0];
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end
`endif

endmodule

// File: doc/syllable_sequencer.md
Name: syllable_sequencer

Overview:
- Sequences a 64-bit instruction bundle of 16 4-bit syllables into a stream of (opcode, immediate) pairs, one per accepted handshake.
- Skips over tail nibbles using the tail-length code, and assembles each tail into a right-aligned immediate.
- Sits between the bundle fetch stage and the stack-machine execute stage.
- Replaces the combinational prefix-offset tree with a registered syllable pointer.

Parameters:
- IMM_W, 32, immediate output width; must be at least 4*MAX_TAIL.
- MAX_TAIL, 8, maximum tail length in nibbles; the table below never exceeds it.

Ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- ir  in  64  bundle; syllable k = ir[4k+3:4k], syllable 0 executes first
- ir_valid  in  1  bundle offered
- ir_ready  out  1  bundle accepted when ir_valid & ir_ready
- flush  in  1  discard current (and buffered) bundle, return to IDLE
- op_valid  out  1  op/imm/op_pc valid
- op_ready  in  1  execute accepts when op_valid & op_ready
- op  out  4  opcode syllable
- imm  out  IMM_W  assembled tail, zero-extended
- op_pc  out  4  syllable index of op
- op_trunc  out  1  tail ran past syllable 15
- op_last  out  1  this op ends the bundle

Behaviour:
- Tail length table (package constant TAIL_LEN), indexed by opcode:
  - 0x0–0xB: 0
  - 0xC: 1
  - 0xD: 2
  - 0xE: 4
  - 0xF: 8
- States:
  - IDLE: no bundle held.
  - RUN: bundle register `bun` and 4-bit pointer `pc` valid.
- Reset values: state=IDLE, pc=0, bun=0.
  - Outputs: ir_ready=1, op_valid=0, op=0, imm=0, op_pc=0, op_trunc=0, op_last=0.
- IDLE:
  - ir_ready=1.
  - On ir accept: bun<=ir, pc<=0, go RUN. op_valid rises the next cycle (1-cycle latency).
- RUN, output decoding:
  - op_valid=1, op=bun[pc], op_pc=pc, len=TAIL_LEN[op].
  - nxt = pc+1+len, computed 5-bit.
  - imm = nibbles pc+1 .. pc+len concatenated. The first tail nibble is most significant; result is right-aligned and zero-extended.
  - Nibbles at index >15 read as 0, and op_trunc = (pc+len > 15).
  - op_last = (nxt > 15).
  - All outputs are combinational from registered state only; there is no ir→op combinational path.
- RUN, on op accept:
  - If op_last: go IDLE, pc<=0.
  - Else: pc<=nxt[3:0].
- Without backpressure, throughput is one op per cycle. op_valid is held, and all op outputs stay stable, until accepted.
- Without optional feature: ir_ready=0 in RUN. There is one bubble cycle between bundles: last op accept → IDLE → accept new bundle → RUN.
- flush:
  - Highest priority: state<=IDLE, pc<=0 next cycle, regardless of any handshake in that cycle.
  - A simultaneous ir accept is dropped.
  - A simultaneous op accept counts as consumed.
- rst mid-RUN: same as flush, plus bun cleared.
- Wrap-around: pc never wraps. Bundle end is decided by the 5-bit nxt.

Optional Feature:
- SYLLABLE_SEQ_PREFETCH_EN: adds a one-entry bundle buffer `nbun` with valid bit `nv`.
  - ir_ready = !nv.
  - A bundle accepted in RUN fills nbun.
  - On last-op accept with nv=1: bun<=nbun, pc<=0, stay RUN, nv<=0 (zero-bubble handoff).
  - A simultaneous last-op accept and ir accept with nv=0 loads ir straight into bun.
  - flush and rst clear nv.
- Without the macro: behaviour exactly as above; nbun and nv are absent.

Decomposition:
- Package syllable_pkg holds:
  - TAIL_LEN table function
  - state enum {IDLE, RUN}
  - SYL_W=4, SYL_N=16
- One sub-module, tail_gather: combinational bun+pc → imm, op_trunc. It uses a nibble shifter and masks by len.
- The FSM and pointer stay in the top module.

Test Plan:
- Basic sequencing: ir=64'h0000_0000_0000_A5C1, op_ready=1.
  - 15 ops, op_pc 0,1,3,4..15 in that order.
  - (0x1,imm 0), (0xC,imm 5), (0xA,imm 0), then twelve (0x0,0).
  - op_last only at op_pc=15.
- Long tail: syllable0=0xF, syllables1..8=1,2,3,4,5,6,7,8.
  - First op is F with imm=32'h12345678.
  - Next op_pc=9.
- Truncated tail: syllable14=0xE, syllable15=0x9, earlier syllables 0.
  - Op at pc14 has imm=0x9000 (missing nibbles read as zero), op_trunc=1, op_last=1.
- Backpressure: hold op_ready=0 for 5 cycles at pc=1 of the basic bundle.
  - op, imm and op_pc stay stable; pc does not advance; the sequence resumes intact.
- Flush/reset: assert flush at pc=3 together with ir_valid.
  - Next cycle IDLE, op_valid=0, offered bundle not taken.
  - Repeat with rst: all outputs at reset values.
- Prefetch (with macro): two back-to-back bundles, op_ready=1.
  - op_valid never drops between the last op of bundle 1 and op_pc=0 of bundle 2.
  - ir_ready=0 while nv=1.
